// File: rtl/stack_cpu_controller.sv
// Multi-cycle control unit for the 8-bit stack processor.
// Owns pc, ir and the zero flag, and sequences memory, stack and ALU
// through fetch / decode / execute. Every strobe is a Moore decode of the
// registered state and ir, so an asynchronous reset drops them at once.
module stack_cpu_controller (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] mem_data,
  input  logic       alu_zero,
  output logic [4:0] mem_addr,
  output logic       mem_read,
  output logic       mem_write,
  output logic       stk_push,
  output logic       stk_pop,
  output logic       stk_src,
  output logic       load_a,
  output logic       load_b,
  output logic [1:0] alu_op,
  output logic [4:0] pc,
  output logic       zero_flag,
  output logic       instr_done
);

  typedef enum logic [2:0] {
    S_FETCH    = 3'd0,
    S_DECODE   = 3'd1,
    S_POP_A    = 3'd2,
    S_POP_B    = 3'd3,
    S_ALU_WB   = 3'd4,
    S_PUSH_MEM = 3'd5,
    S_POP_MEM  = 3'd6
  } state_t;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_NOT  = 3'b011;
  localparam logic [2:0] OP_PUSH = 3'b100;
  localparam logic [2:0] OP_POP  = 3'b101;
  localparam logic [2:0] OP_JMP  = 3'b110;
  localparam logic [2:0] OP_JZ   = 3'b111;

  state_t     state_q, state_d;
  logic [4:0] pc_q, pc_d;
  logic [7:0] ir_q, ir_d;
  logic       zero_q, zero_d;

  logic [2:0] opcode_s;
  logic [4:0] operand_s;

  assign opcode_s  = ir_q[7:5];
  assign operand_s = ir_q[4:0];
  assign pc        = pc_q;
  assign zero_flag = zero_q;

  // State, pc, ir and zero flag registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      pc_q    <= 5'd0;
      ir_q    <= 8'd0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      zero_q  <= zero_d;
    end
  end

  // Next-state logic and Moore strobe decode of the current state and ir.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    zero_d     = zero_q;
    mem_addr   = 5'd0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    stk_push   = 1'b0;
    stk_pop    = 1'b0;
    stk_src    = 1'b0;
    load_a     = 1'b0;
    load_b     = 1'b0;
    alu_op     = 2'b00;
    instr_done = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_addr = pc_q;
        mem_read = 1'b1;
        ir_d     = mem_data;
        pc_d     = pc_q + 5'd1;  // wraps 31 -> 0 naturally
        state_d  = S_DECODE;
      end
      S_DECODE: begin
        case (opcode_s)
          OP_ADD, OP_SUB, OP_AND, OP_NOT: state_d = S_POP_A;
          OP_PUSH: state_d = S_PUSH_MEM;
          OP_POP:  state_d = S_POP_MEM;
          OP_JMP: begin
            pc_d       = operand_s;
            instr_done = 1'b1;
            state_d    = S_FETCH;
          end
          OP_JZ: begin
            if (zero_q) begin
              pc_d = operand_s;
            end else begin
              pc_d = pc_q;
            end
            instr_done = 1'b1;
            state_d    = S_FETCH;
          end
          default: state_d = S_FETCH;
        endcase
      end
      S_POP_A: begin
        stk_pop = 1'b1;
        load_a  = 1'b1;
        // Unary not needs only one operand, so it skips POP_B.
        if (opcode_s == OP_NOT) begin
          state_d = S_ALU_WB;
        end else begin
          state_d = S_POP_B;
        end
      end
      S_POP_B: begin
        stk_pop = 1'b1;
        load_b  = 1'b1;
        state_d = S_ALU_WB;
      end
      S_ALU_WB: begin
        alu_op     = ir_q[6:5];
        stk_src    = 1'b0;
        stk_push   = 1'b1;
        instr_done = 1'b1;
        zero_d     = alu_zero;
        state_d    = S_FETCH;
      end
      S_PUSH_MEM: begin
        mem_addr   = operand_s;
        mem_read   = 1'b1;
        stk_src    = 1'b1;
        stk_push   = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_POP_MEM: begin
        mem_addr   = operand_s;
        mem_write  = 1'b1;
        stk_pop    = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_stack_cpu_controller.sv
// Directed bench for stack_cpu_controller: a behavioural memory, stack and
// ALU surround the controller; expected values are hand-computed per step.
module tb_stack_cpu_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] mem_data;
  logic       alu_zero;
  logic [4:0] mem_addr;
  logic       mem_read, mem_write, stk_push, stk_pop, stk_src, load_a, load_b;
  logic [1:0] alu_op;
  logic [4:0] pc;
  logic       zero_flag, instr_done;

  stack_cpu_controller dut (
    .clk(clk), .rst_n(rst_n), .mem_data(mem_data), .alu_zero(alu_zero),
    .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
    .stk_push(stk_push), .stk_pop(stk_pop), .stk_src(stk_src),
    .load_a(load_a), .load_b(load_b), .alu_op(alu_op), .pc(pc),
    .zero_flag(zero_flag), .instr_done(instr_done)
  );

  always #5 clk = ~clk;

  // Environment: memory, stack and ALU
  logic [7:0] mem [0:31];
  logic [7:0] stk [0:31];
  logic [4:0] sp;
  logic [7:0] a_r, b_r, alu_res, stk_top, push_val;
  logic       rand_en;
  logic [7:0] rand_val;

  assign mem_data = rand_en ? rand_val : mem[mem_addr];
  assign stk_top  = stk[sp - 5'd1];
  assign push_val = stk_src ? mem_data : alu_res;
  assign alu_zero = (alu_res == 8'd0);

  // ALU model
  always_comb begin
    case (alu_op)
      2'b00:   alu_res = b_r + a_r;
      2'b01:   alu_res = b_r - a_r;
      2'b10:   alu_res = b_r & a_r;
      default: alu_res = ~a_r;
    endcase
  end

  // Stack and operand latch model
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp  <= 5'd0;
      a_r <= 8'd0;
      b_r <= 8'd0;
    end else begin
      if (stk_push) begin
        stk[sp] <= push_val;
        sp      <= sp + 5'd1;
      end else if (stk_pop) begin
        sp <= sp - 5'd1;
      end
      if (load_a) a_r <= stk_top;
      if (load_b) b_r <= stk_top;
    end
  end

  // Memory write port
  always @(posedge clk) begin
    if (mem_write) mem[mem_addr] <= stk_top;
  end

  int n_cmp = 0;
  int n_err = 0;
  int cyc;
  int done_q[$];
  int wr_cnt, wr_cyc;
  logic [4:0] wr_addr;
  logic [7:0] wr_top;

  function automatic logic [7:0] enc(input logic [2:0] op, input logic [4:0] arg);
    return {op, arg};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic mem_w(input logic [4:0] a, input logic [7:0] v);
    mem[a] <= v;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 32; i++) mem[i] <= 8'h00;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    #1;
    cyc++;
    if (instr_done) done_q.push_back(cyc);
    if (mem_write) begin
      wr_cnt++;
      wr_cyc  = cyc;
      wr_addr = mem_addr;
      wr_top  = stk_top;
    end
  endtask

  task automatic step_to(input int c);
    while (cyc < c) step();
  endtask

  task automatic enter_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
  endtask

  // Release on a falling edge; cycle 1 is the FETCH ending at the next rise.
  task automatic release_reset();
    @(negedge clk);
    rst_n   = 1'b1;
    rand_en = 1'b0;
    #1;
    cyc    = 1;
    wr_cnt = 0;
    wr_cyc = 0;
    done_q.delete();
  endtask

  task automatic chk_done(input string tag, input int exp[]);
    chk({tag, "_count"}, 32'(done_q.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size(); i++) begin
      if (i < done_q.size()) chk($sformatf("%s_%0d", tag, i), 32'(done_q[i]), 32'(exp[i]));
      else chk($sformatf("%s_%0d", tag, i), 32'(0), 32'(exp[i]));
    end
  endtask

  initial begin
    // Reset with random memory data
    rst_n    = 1'b0;
    rand_en  = 1'b1;
    rand_val = 8'h00;
    clear_mem();
    for (int i = 0; i < 5; i++) mem_w(5'(i), enc(3'b100, 5'(25 + i)));
    for (int i = 5; i < 9; i++) mem_w(5'(i), enc(3'b000, 5'd0));
    mem_w(5'd9, enc(3'b101, 5'd30));
    mem_w(5'd25, 8'd9); mem_w(5'd26, 8'd7); mem_w(5'd27, 8'd5);
    mem_w(5'd28, 8'd3); mem_w(5'd29, 8'd1);
    mem_w(5'd30, 8'hEE);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      rand_val = 8'($urandom);
      #1;
      chk("rst_pc", 32'(pc), 32'd0);
      chk("rst_zero", 32'(zero_flag), 32'd0);
      chk("rst_mem_read", 32'(mem_read), 32'd1);
      chk("rst_mem_addr", 32'(mem_addr), 32'd0);
      chk("rst_others", 32'({mem_write, stk_push, stk_pop, stk_src, load_a, load_b, alu_op, instr_done}), 32'd0);
    end

    // Sum program: 9+7+5+3+1 stored to mem[30]
    release_reset();
    chk("sum_c1_read", 32'(mem_read), 32'd1);
    chk("sum_c1_addr", 32'(mem_addr), 32'd0);
    step();
    chk("sum_c2_pc", 32'(pc), 32'd1);
    chk("sum_c2_decode", 32'({mem_read, stk_push, stk_pop, instr_done}), 32'd0);
    step_to(38);
    chk("sum_c38_write", 32'(mem_write), 32'd1);
    chk("sum_c38_done", 32'(instr_done), 32'd1);
    step_to(40);
    chk("sum_wr_count", 32'(wr_cnt), 32'd1);
    chk("sum_wr_cycle", 32'(wr_cyc), 32'd38);
    chk("sum_wr_addr", 32'(wr_addr), 32'd30);
    chk("sum_wr_top", 32'(wr_top), 32'd25);
    chk("sum_mem30", 32'(mem[30]), 32'd25);
    chk("sum_done_count", 32'(done_q.size()), 32'd10);
    chk("sum_zero", 32'(zero_flag), 32'd0);

    // Sub to zero, then jz taken to 15
    enter_reset();
    clear_mem();
    mem_w(5'd0, enc(3'b100, 5'd8));
    mem_w(5'd1, enc(3'b100, 5'd8));
    mem_w(5'd2, enc(3'b001, 5'd0));
    mem_w(5'd3, enc(3'b111, 5'd15));
    mem_w(5'd8, 8'd8);
    release_reset();
    step_to(10);
    chk("sub_popb", 32'({stk_pop, load_a, load_b}), 32'b101);
    step_to(11);
    chk("sub_alu_op", 32'(alu_op), 32'b01);
    chk("sub_wb_push", 32'({stk_push, stk_src}), 32'b10);
    step_to(12);
    chk("sub_zero", 32'(zero_flag), 32'd1);
    chk("sub_top", 32'(stk_top), 32'd0);
    step_to(14);
    chk("jz_taken_addr", 32'(mem_addr), 32'd15);
    chk("jz_taken_read", 32'(mem_read), 32'd1);
    chk_done("sub_done", '{3, 6, 11, 13});

    // Add nonzero, jmp 7, jz 12 falls through to 8
    enter_reset();
    clear_mem();
    mem_w(5'd0, enc(3'b100, 5'd8));
    mem_w(5'd1, enc(3'b100, 5'd8));
    mem_w(5'd2, enc(3'b000, 5'd0));
    mem_w(5'd3, enc(3'b110, 5'd7));
    mem_w(5'd7, enc(3'b111, 5'd12));
    mem_w(5'd8, 8'd8);
    release_reset();
    step_to(12);
    chk("add_zero", 32'(zero_flag), 32'd0);
    chk("add_top", 32'(stk_top), 32'd16);
    step_to(14);
    chk("jmp_addr", 32'(mem_addr), 32'd7);
    step_to(16);
    chk("jz_fall_addr", 32'(mem_addr), 32'd8);
    chk("jz_fall_pc", 32'(pc), 32'd8);
    chk_done("jmp_done", '{3, 6, 11, 13, 15});

    // Not: push 0xFF, not -> 0, no POP_B state
    enter_reset();
    clear_mem();
    mem_w(5'd0, enc(3'b100, 5'd10));
    mem_w(5'd1, enc(3'b011, 5'd0));
    mem_w(5'd10, 8'hFF);
    release_reset();
    step_to(6);
    chk("not_popa", 32'({stk_pop, load_a, load_b}), 32'b110);
    step_to(7);
    chk("not_alu_op", 32'(alu_op), 32'b11);
    chk("not_wb", 32'({stk_push, instr_done, load_b}), 32'b110);
    step_to(8);
    chk("not_fetch_addr", 32'({mem_read, mem_addr}), 32'({1'b1, 5'd2}));
    chk("not_zero", 32'(zero_flag), 32'd1);
    chk_done("not_done", '{3, 7});

    // Reset in the middle of POP_MEM: no write commits
    enter_reset();
    clear_mem();
    mem_w(5'd0, enc(3'b100, 5'd12));
    mem_w(5'd1, enc(3'b101, 5'd20));
    mem_w(5'd12, 8'h5A);
    mem_w(5'd20, 8'h33);
    release_reset();
    step_to(6);
    chk("popm_strobes", 32'({mem_write, stk_pop, instr_done}), 32'b111);
    chk("popm_addr", 32'(mem_addr), 32'd20);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_strobes", 32'({mem_write, stk_pop, stk_push, instr_done}), 32'd0);
    chk("midrst_pc", 32'(pc), 32'd0);
    chk("midrst_read", 32'({mem_read, mem_addr}), 32'({1'b1, 5'd0}));
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("midrst_mem20", 32'(mem[20]), 32'h33);

    // Wrap: jmp 31, mem[31] = jmp 0
    clear_mem();
    mem_w(5'd0, enc(3'b110, 5'd31));
    mem_w(5'd31, enc(3'b110, 5'd0));
    release_reset();
    step_to(3);
    chk("wrap_fetch31", 32'({pc, mem_addr}), 32'({5'd31, 5'd31}));
    step_to(4);
    chk("wrap_pc0", 32'(pc), 32'd0);
    step_to(5);
    chk("wrap_refetch0", 32'({mem_read, mem_addr}), 32'({1'b1, 5'd0}));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
